// File: rtl/fifo_ctrl_if.sv
// Push/pop request and memoria drive bundle between a FIFO user and fifo_ctrl.
// The master is the FIFO user. The slave is the controller.
interface fifo_ctrl_if #(parameter int PTR_WIDTH = 3);
  logic                 push, pop;
  logic                 write, read, data_valid;
  logic [PTR_WIDTH-1:0] ptr_write, ptr_read;
  logic [PTR_WIDTH:0]   count;
  logic                 full, empty, almost_full, almost_empty;
  logic                 overflow, underflow;

  modport master (
    output push, pop,
    input  write, read, ptr_write, ptr_read, data_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output write, read, ptr_write, ptr_read, data_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller that drives the memoria block as a synchronous FIFO.
// Flags decode from registered state only. Error flags stay set until reset.
module fifo_ctrl #(
  parameter int LENGTH          = 8,
  parameter int PTR_WIDTH       = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LENGTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t               state, state_nxt;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 dv, ovf, unf;
  logic                 is_full, is_empty, wr, rd;

  assign is_full  = (state == FULL);
  assign is_empty = (state == EMPTY);

  // A full FIFO rejects push and an empty one rejects pop, so wr and rd never target the same live slot.
  assign wr = bus.push & ~is_full  & ~reset;
  assign rd = bus.pop  & ~is_empty & ~reset;

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    unique case ({wr, rd})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
    unique case (state)
      EMPTY:   if (wr) state_nxt = PARTIAL;
      PARTIAL: begin
        if (wr && !rd && cnt == CNT_MAX - CW'(1)) state_nxt = FULL;
        else if (rd && !wr && cnt == CW'(1))      state_nxt = EMPTY;
      end
      FULL:    if (rd) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dv     <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      if (wr) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      dv     <= rd;
      if (bus.push && is_full)  ovf <= 1'b1;
      if (bus.pop  && is_empty) unf <= 1'b1;
    end
  end

  assign bus.write        = wr;
  assign bus.read         = rd;
  assign bus.ptr_write    = wr_ptr;
  assign bus.ptr_read     = rd_ptr;
  assign bus.data_valid   = dv;
  assign bus.count        = cnt;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_TH);
  assign bus.almost_empty = (cnt <= AE_TH);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl. A small memoria stand-in feeds data_out.
// A queue-based FIFO model is the reference, run through directed steps and then random traffic.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] din, dout;
  logic [9:0] mem [8];

  int n_cmp = 0;
  int n_err = 0;

  int q[$];
  int m_wp, m_rp, m_last;
  bit m_ov, m_un, m_dv;

  fifo_ctrl_if #(.PTR_WIDTH(3)) bus ();

  fifo_ctrl #(.LENGTH(8), .PTR_WIDTH(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memoria stand-in: registered write, registered read data
  always @(posedge clk) begin
    if (bus.write) mem[bus.ptr_write] <= din;
    if (bus.read)  dout <= mem[bus.ptr_read];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit p, input bit po, input bit rst, input logic [9:0] d);
    bit exp_w, exp_r;
    int sz;
    @(negedge clk);
    bus.push = p; bus.pop = po; reset = rst; din = d;
    #1;
    sz    = q.size();
    exp_w = !rst && p  && (sz < 8);
    exp_r = !rst && po && (sz > 0);
    chk("write", {31'b0, bus.write}, {31'b0, exp_w});
    chk("read",  {31'b0, bus.read},  {31'b0, exp_r});
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete(); m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0; m_dv = 0;
    end else begin
      if (p && sz == 8)  m_ov = 1;
      if (po && sz == 0) m_un = 1;
      if (exp_r) begin m_last = q.pop_front(); m_rp = (m_rp + 1) % 8; end
      if (exp_w) begin q.push_back(int'(d));   m_wp = (m_wp + 1) % 8; end
      m_dv = exp_r;
    end
    sz = q.size();
    chk("count",        32'(bus.count),        32'(sz));
    chk("full",         32'(bus.full),         32'(sz == 8));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= 6));
    chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
    chk("overflow",     32'(bus.overflow),     32'(m_ov));
    chk("underflow",    32'(bus.underflow),    32'(m_un));
    chk("ptr_write",    32'(bus.ptr_write),    32'(m_wp));
    chk("ptr_read",     32'(bus.ptr_read),     32'(m_rp));
    chk("data_valid",   32'(bus.data_valid),   32'(m_dv));
    if (m_dv) chk("data_out", 32'(dout), 32'(m_last));
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; reset = 1; din = '0;
    m_wp = 0; m_rp = 0; m_last = 0; m_ov = 0; m_un = 0; m_dv = 0;

    step(0, 0, 1, 10'h0);
    step(0, 0, 1, 10'h0);
    repeat (3) step(0, 0, 0, 10'h0);

    for (int i = 1; i <= 8; i++) step(1, 0, 0, 10'(i));
    step(1, 0, 0, 10'h3ff);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 10'h0);

    step(0, 1, 0, 10'h0);
    step(1, 1, 0, 10'h0aa);
    step(0, 1, 0, 10'h0);

    for (int i = 0; i < 4; i++) step(1, 0, 0, 10'(10'h100 + i));
    for (int i = 0; i < 10; i++) step(1, 1, 0, 10'(10'h200 + i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'h0);

    for (int i = 0; i < 8; i++) step(1, 0, 0, 10'(10'h300 + i));
    step(1, 1, 0, 10'h155);
    step(1, 1, 0, 10'h156);

    step(0, 0, 1, 10'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 10'(10'h050 + i));
    step(0, 1, 0, 10'h0);
    step(1, 0, 1, 10'h3c3);
    step(0, 0, 0, 10'h0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 59) == 0, 10'($urandom_range(0, 1023)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer/flag controller that turns the 8-entry x 10-bit `memoria` storage block into a synchronous FIFO. It accepts push/pop requests from upstream and downstream logic, and drives the memory's write, read, ptr_write and ptr_read inputs. It tracks occupancy, and reports full/empty, almost-full/almost-empty and sticky error flags. It sits beside `memoria` and replaces the probador as its driver in the FIFO datapath.

Parameters:
- LENGTH, 8, number of memory entries; power of two.
- PTR_WIDTH, 3, pointer width; log2(LENGTH).
- ALMOST_FULL_TH, 6, almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  request to write the current data_in word into the FIFO.
- pop  input  1  request to read the oldest word from the FIFO.
- write  output  1  write enable to memoria.
- read  output  1  read enable to memoria.
- ptr_write  output  PTR_WIDTH  write address to memoria.
- ptr_read  output  PTR_WIDTH  read address to memoria.
- data_valid  output  1  memoria data_out holds the popped word this cycle.
- count  output  PTR_WIDTH+1  occupancy, 0..LENGTH.
- full  output  1  count == LENGTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- overflow  output  1  sticky flag: a push arrived while full.
- underflow  output  1  sticky flag: a pop arrived while empty.

Behaviour:
- Reset (sampled on the clock edge while reset=1) sets:
  - ptr_write=0, ptr_read=0, count=0, state=EMPTY.
  - data_valid=0, overflow=0, underflow=0.
  - Resulting outputs: write=0, read=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset takes priority over push/pop in the same cycle.
- Acceptance (combinational from registered state):
  - write = push & ~full & ~reset.
  - read = pop & ~empty & ~reset.
  - ptr_write and ptr_read are registered and presented directly to memoria.
- Pointer update on an accepted operation: that pointer increments by 1 at the clock edge, modulo LENGTH (7 wraps to 0).
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Read latency: memoria registers data_out on read. data_valid is a register equal to the previous cycle's read, so it is high exactly one cycle after each accepted pop.
- Simultaneous push and pop:
  - Partially filled: both are accepted. Both pointers advance, count is unchanged.
  - Full: pop is accepted and push is rejected, so the same-address write/read hazard never occurs. overflow is set and count goes to LENGTH-1.
  - Empty: push is accepted and pop is rejected. underflow is set and count goes to 1. No read-through/bypass.
- Error flags:
  - overflow is set at the edge when push=1 & full=1.
  - underflow is set at the edge when pop=1 & empty=1.
  - Both hold until reset; rejected operations have no other side effect.
- State machine (registered, must always agree with count):
  - EMPTY: to PARTIAL on an accepted write.
  - PARTIAL: to FULL when a write only brings count to LENGTH; to EMPTY when a read only brings count to 0; otherwise stays.
  - FULL: to PARTIAL on an accepted read.
- Flags are decoded from the registered count/state only, so they are glitch-free and never depend on push/pop combinationally.
- Reset mid-operation: any in-flight data_valid is cleared the next cycle. FIFO contents are logically discarded because pointers return to 0; memory contents are not cleared.

Test Plan:
- Reset then idle for 3 cycles -> empty=1, almost_empty=1, count=0, write=read=0, pointers=0, flags=0.
- Push 8 words 0x001..0x008 on consecutive cycles -> count 1..8; almost_full high from count=6; full=1 after the 8th; ptr_write wraps back to 0.
- With the FIFO full, assert push alone -> write=0, overflow=1 the next cycle, count stays 8. Then pop all 8 -> data_out = 0x001..0x008 in order, each one cycle after read, with data_valid high.
- Pop while empty -> read=0, underflow=1, count=0. Then push+pop together -> count=1, write=1, read=0.
- Fill to 4, then push+pop together for 10 cycles -> count stays 4, both pointers wrap past 7, data_out stays in FIFO order.
- Fill to 5, assert reset with push=1 -> next cycle count=0, ptr_write=ptr_read=0, empty=1, overflow=underflow=0, data_valid=0.
